// File: rtl/axis_hdr_pkg.sv
// Shared constants, state encoding and byte-lane helpers for the AXI-Stream
// header inserter.
package axis_hdr_pkg;

  localparam int DATA_WD = 32;
  localparam int BYTES   = DATA_WD / 8;
  localparam int BCNT_WD = $clog2(BYTES);
  // Byte counts run 1..BYTES, so they need one bit more than BCNT_WD.
  localparam int NCNT_WD = $clog2(BYTES + 1);
  localparam int SUM_WD  = NCNT_WD + 1;

  typedef enum logic [1:0] {IDLE, HOLD, STREAM, TAIL} state_t;

  function automatic logic [NCNT_WD-1:0] popcount(input logic [BYTES-1:0] keep);
    logic [NCNT_WD-1:0] c;
    c = '0;
    for (int i = 0; i < BYTES; i++) c = c + NCNT_WD'(keep[i]);
    return c;
  endfunction

  function automatic logic [BYTES-1:0] keep_from_count(input logic [SUM_WD-1:0] n);
    logic [BYTES-1:0] k;
    k = '0;
    for (int i = 0; i < BYTES; i++) k[BYTES-1-i] = (SUM_WD'(i) < n);
    return k;
  endfunction

  function automatic logic [DATA_WD-1:0] keep_to_mask(input logic [BYTES-1:0] keep);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < BYTES; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] low_mask(input logic [NCNT_WD-1:0] n);
    logic [DATA_WD-1:0] m;
    m = '1;
    return ~(m << {n, 3'b000});
  endfunction

endpackage

// File: rtl/axis_header_inserter_merge.sv
// Combinational byte merge: residual bytes followed by the top of the payload
// word, plus the bytes of the payload word that carry over to the next beat.
module axis_byte_merge
  import axis_hdr_pkg::*;
(
  input  logic [DATA_WD-1:0] i_res,
  input  logic [NCNT_WD-1:0] i_n,
  input  logic [DATA_WD-1:0] i_data,
  output logic [DATA_WD-1:0] o_beat,
  output logic [DATA_WD-1:0] o_res
);

  assign o_beat = DATA_WD'({i_res, i_data} >> {i_n, 3'b000});
  assign o_res  = i_data & low_mask(i_n);

endmodule

// File: rtl/axis_header_inserter.sv
// Prepends a 1..BYTES byte header to each AXI-Stream packet and emits the
// result byte-packed MSB-first with a registered output stage.
//   IDLE   | waiting for a header; payload stalled
//   HOLD   | header latched, no payload beat taken yet
//   STREAM | payload flowing, residual carries N bytes
//   TAIL   | last payload taken, overflow bytes still to emit
module axis_header_inserter
  import axis_hdr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [DATA_WD-1:0] data_in,
  input  logic [BYTES-1:0]   keep_in,
  input  logic               last_in,
  output logic               ready_in,
  input  logic               valid_insert,
  input  logic [DATA_WD-1:0] data_insert,
  input  logic [BYTES-1:0]   keep_insert,
  input  logic [BCNT_WD-1:0] byte_insert_cnt,
  output logic               ready_insert,
  output logic               valid_out,
  output logic [DATA_WD-1:0] data_out,
  output logic [BYTES-1:0]   keep_out,
  output logic               last_out,
  input  logic               ready_out
);

  state_t             r_state, w_state_nxt;
  logic [NCNT_WD-1:0] r_n, r_tail_n;
  logic [DATA_WD-1:0] r_res;
  logic               r_valid_out, r_last_out;
  logic [DATA_WD-1:0] r_data_out;
  logic [BYTES-1:0]   r_keep_out;

  logic               w_slot, w_acc_in, w_fits;
  logic               w_ld_hdr, w_ld_beat, w_ld_tail;
  logic [SUM_WD-1:0]  w_sum;
  logic [DATA_WD-1:0] w_data_msk, w_beat, w_res_nxt;

  assign w_slot       = !r_valid_out || ready_out;
  assign ready_in     = (r_state == HOLD || r_state == STREAM) && w_slot;
  // In TAIL the next header may be taken as the final beat leaves.
  assign ready_insert = (r_state == IDLE) ||
                        (r_state == TAIL && r_valid_out && r_last_out && ready_out);
  assign w_acc_in     = valid_in && ready_in;
  assign w_sum        = SUM_WD'(r_n) + SUM_WD'(popcount(keep_in));
  assign w_fits       = w_sum <= SUM_WD'(BYTES);
  assign w_data_msk   = data_in & keep_to_mask(keep_in);

  axis_byte_merge u_merge (
    .i_res  (r_res),
    .i_n    (r_n),
    .i_data (w_data_msk),
    .o_beat (w_beat),
    .o_res  (w_res_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ld_hdr    = 1'b0;
    w_ld_beat   = 1'b0;
    w_ld_tail   = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid_insert) begin
          w_ld_hdr    = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD, STREAM: begin
        if (w_acc_in) begin
          w_ld_beat = 1'b1;
          if (!last_in)    w_state_nxt = STREAM;
          else if (w_fits) w_state_nxt = IDLE;
          else             w_state_nxt = TAIL;
        end
      end
      TAIL: begin
        if (r_valid_out && r_last_out) begin
          if (ready_out) begin
            w_state_nxt = IDLE;
            if (valid_insert) begin
              w_ld_hdr    = 1'b1;
              w_state_nxt = HOLD;
            end
          end
        end else if (w_slot) begin
          w_ld_tail = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n      <= '0;
      r_res    <= '0;
      r_tail_n <= '0;
    end else if (w_ld_hdr) begin
      r_n   <= popcount(keep_insert);
      r_res <= data_insert & keep_to_mask(keep_insert);
    end else if (w_ld_beat) begin
      r_res    <= w_res_nxt;
      r_tail_n <= NCNT_WD'(w_sum - SUM_WD'(BYTES));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_keep_out  <= '0;
      r_last_out  <= 1'b0;
    end else if (w_ld_beat) begin
      r_valid_out <= 1'b1;
      r_data_out  <= w_beat;
      r_keep_out  <= (last_in && w_fits) ? keep_from_count(w_sum) : '1;
      r_last_out  <= last_in && w_fits;
    end else if (w_ld_tail) begin
      // Overflow bytes sit in the residual's upper valid lanes; shift them to the MSB end.
      r_valid_out <= 1'b1;
      r_data_out  <= r_res << {NCNT_WD'(BYTES) - r_n, 3'b000};
      r_keep_out  <= keep_from_count(SUM_WD'(r_tail_n));
      r_last_out  <= 1'b1;
    end else if (ready_out) begin
      r_valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && valid_insert && ready_insert)
      assert (keep_insert != '0 &&
              popcount(keep_insert) == NCNT_WD'(byte_insert_cnt) + NCNT_WD'(1));
  end

  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign keep_out  = r_keep_out;
  assign last_out  = r_last_out;

endmodule

// File: tb/tb_axis_header_inserter.sv
// Bench for axis_header_inserter: fixed vectors, payload-before-header,
// randomized traffic against a byte-queue model, and mid-packet reset.
module tb_axis_header_inserter;
  import axis_hdr_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               valid_in = 1'b0, last_in = 1'b0, ready_in;
  logic [DATA_WD-1:0] data_in = '0;
  logic [BYTES-1:0]   keep_in = '0;
  logic               valid_insert = 1'b0, ready_insert;
  logic [DATA_WD-1:0] data_insert = '0;
  logic [BYTES-1:0]   keep_insert = '0;
  logic [BCNT_WD-1:0] byte_insert_cnt = '0;
  logic               valid_out, last_out, ready_out = 1'b1;
  logic [DATA_WD-1:0] data_out;
  logic [BYTES-1:0]   keep_out;

  axis_header_inserter dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_WD-1:0] d;
    logic [BYTES-1:0]   k;
    logic               l;
  } beat_t;

  typedef struct {
    logic [DATA_WD-1:0]            hd;
    logic [BYTES-1:0]              hk;
    int                            np;
    logic [3:0][DATA_WD-1:0]       pd;
    logic [3:0][BYTES-1:0]         pk;
    int                            no;
    logic [3:0][DATA_WD-1:0]       od;
    logic [3:0][BYTES-1:0]         ok;
  } vec_t;

  beat_t hq[$], pq[$], eq[$];
  beat_t cur_h, cur_p, prev_o, e;
  int    n_vec = 0, n_bad = 0;
  bit    rnd = 1'b0, hdr_busy = 1'b0, pl_busy = 1'b0, stall_pend = 1'b0;
  vec_t  tv[3];

  // Expected output = header bytes then payload bytes, chunked into MSB-aligned beats.
  task automatic add_packet_model(input logic [DATA_WD-1:0] hd, input int n, input int len, input int m);
    logic [7:0]       bq[$];
    logic [BYTES-1:0] ones;
    beat_t            b;
    int               cnt;
    ones = '1;
    for (int i = n - 1; i >= 0; i--) bq.push_back(hd[8*i +: 8]);
    hq.push_back('{hd, ~(ones << n), 1'b0});
    for (int j = 0; j < len; j++) begin
      cnt = (j == len - 1) ? m : BYTES;
      b.d = $urandom;
      b.k = ~(ones >> cnt);
      b.l = (j == len - 1);
      for (int i = BYTES - 1; i >= BYTES - cnt; i--) bq.push_back(b.d[8*i +: 8]);
      pq.push_back(b);
    end
    while (bq.size() > 0) begin
      b.d = '0;
      b.k = '0;
      for (int i = BYTES - 1; i >= 0; i--)
        if (bq.size() > 0) begin
          b.d[8*i +: 8] = bq.pop_front();
          b.k[i] = 1'b1;
        end
      b.l = (bq.size() == 0);
      eq.push_back(b);
    end
  endtask

  task automatic drain(input string nm, input int budget);
    int c = 0;
    while ((eq.size() > 0 || hq.size() > 0 || pq.size() > 0 || hdr_busy || pl_busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout: %0d beats still outstanding, required 0", nm, eq.size());
      eq.delete(); hq.delete(); pq.delete();
      hdr_busy = 1'b0; pl_busy = 1'b0;
    end
    repeat (3) @(negedge clk);
    #2;
    n_vec++;
    if (valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_after: valid_out=%b, required 0", nm, valid_out);
    end
  endtask

  task automatic check_idle(input string nm);
    n_vec++;
    if (valid_out !== 1'b0 || last_out !== 1'b0 || keep_out !== '0 || data_out !== '0 ||
        ready_insert !== 1'b1 || ready_in !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: valid=%b last=%b keep=%b data=%h rdy_ins=%b rdy_in=%b, required 0 0 0000 00000000 1 0",
               nm, valid_out, last_out, keep_out, data_out, ready_insert, ready_in);
    end
  endtask

  // Header source
  initial forever begin
    @(negedge clk);
    if (!hdr_busy && hq.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
      cur_h = hq.pop_front();
      hdr_busy = 1'b1;
    end
    valid_insert    = hdr_busy;
    data_insert     = hdr_busy ? cur_h.d : '0;
    keep_insert     = hdr_busy ? cur_h.k : '0;
    byte_insert_cnt = hdr_busy ? BCNT_WD'(popcount(cur_h.k) - NCNT_WD'(1)) : '0;
    #1;
    if (hdr_busy && ready_insert && rst_n) hdr_busy = 1'b0;
  end

  // Payload source
  initial forever begin
    @(negedge clk);
    if (!pl_busy && pq.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
      cur_p = pq.pop_front();
      pl_busy = 1'b1;
    end
    valid_in = pl_busy;
    data_in  = pl_busy ? cur_p.d : '0;
    keep_in  = pl_busy ? cur_p.k : '0;
    last_in  = pl_busy && cur_p.l;
    #1;
    if (pl_busy && ready_in && rst_n) pl_busy = 1'b0;
  end

  // Output sink and checker
  initial forever begin
    @(negedge clk);
    ready_out = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (rst_n) begin
      if (stall_pend) begin
        n_vec++;
        if (valid_out !== 1'b1 || data_out !== prev_o.d || keep_out !== prev_o.k || last_out !== prev_o.l) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%b d=%h k=%b l=%b, required v=1 d=%h k=%b l=%b",
                   valid_out, data_out, keep_out, last_out, prev_o.d, prev_o.k, prev_o.l);
        end
      end
      if (valid_out === 1'b1 && ready_out) begin
        n_vec++;
        if (eq.size() == 0) begin
          n_bad++;
          $display("FAIL out_beat: got d=%h k=%b l=%b, required no beat", data_out, keep_out, last_out);
        end else begin
          e = eq.pop_front();
          if (data_out !== e.d || keep_out !== e.k || last_out !== e.l) begin
            n_bad++;
            $display("FAIL out_beat: got d=%h k=%b l=%b, required d=%h k=%b l=%b",
                     data_out, keep_out, last_out, e.d, e.k, e.l);
          end
        end
      end
      stall_pend = (valid_out === 1'b1) && !ready_out;
      prev_o = '{data_out, keep_out, last_out};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t h;
    tv[0].hd = 32'hAABBCCDD; tv[0].hk = 4'b0011; tv[0].np = 2;
    tv[0].pd[0] = 32'h11223344; tv[0].pk[0] = 4'b1111;
    tv[0].pd[1] = 32'h55667788; tv[0].pk[1] = 4'b1100;
    tv[0].no = 2;
    tv[0].od[0] = 32'hCCDD1122; tv[0].ok[0] = 4'b1111;
    tv[0].od[1] = 32'h33445566; tv[0].ok[1] = 4'b1111;
    tv[1].hd = 32'hAABBCCDD; tv[1].hk = 4'b0111; tv[1].np = 1;
    tv[1].pd[0] = 32'h11223344; tv[1].pk[0] = 4'b1110;
    tv[1].no = 2;
    tv[1].od[0] = 32'hBBCCDD11; tv[1].ok[0] = 4'b1111;
    tv[1].od[1] = 32'h22330000; tv[1].ok[1] = 4'b1100;
    tv[2].hd = 32'hA1A2A3A4; tv[2].hk = 4'b1111; tv[2].np = 3;
    tv[2].pd[0] = 32'h01020304; tv[2].pk[0] = 4'b1111;
    tv[2].pd[1] = 32'h05060708; tv[2].pk[1] = 4'b1111;
    tv[2].pd[2] = 32'h090A0B0C; tv[2].pk[2] = 4'b1111;
    tv[2].no = 4;
    tv[2].od[0] = 32'hA1A2A3A4; tv[2].ok[0] = 4'b1111;
    tv[2].od[1] = 32'h01020304; tv[2].ok[1] = 4'b1111;
    tv[2].od[2] = 32'h05060708; tv[2].ok[2] = 4'b1111;
    tv[2].od[3] = 32'h090A0B0C; tv[2].ok[3] = 4'b1111;

    repeat (3) @(negedge clk);
    #2;
    check_idle("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check_idle("after_release");

    // Fixed vectors, pushed back to back so headers follow final beats directly.
    for (int t = 0; t < 3; t++) begin
      hq.push_back('{tv[t].hd, tv[t].hk, 1'b0});
      for (int j = 0; j < tv[t].np; j++) pq.push_back('{tv[t].pd[j], tv[t].pk[j], j == tv[t].np - 1});
      for (int j = 0; j < tv[t].no; j++) eq.push_back('{tv[t].od[j], tv[t].ok[j], j == tv[t].no - 1});
    end
    drain("table", 500);

    // Payload offered before any header must stall.
    add_packet_model(32'h3C4D5E6F, 2, 3, 3);
    h = hq.pop_back();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2;
      n_vec++;
      if (ready_in !== 1'b0 || valid_out !== 1'b0) begin
        n_bad++;
        $display("FAIL early_payload: ready_in=%b valid_out=%b, required 0 0", ready_in, valid_out);
      end
    end
    hq.push_back(h);
    drain("early_payload", 500);

    // Random traffic with 50% output backpressure.
    rnd = 1'b1;
    for (int p = 0; p < 200; p++)
      add_packet_model($urandom, $urandom_range(1, BYTES), $urandom_range(1, 4), $urandom_range(1, BYTES));
    drain("random", 20000);
    rnd = 1'b0;

    // Reset in the middle of a packet.
    add_packet_model(32'h0A0B0C0D, 3, 4, 2);
    begin
      int c = 0;
      do begin
        @(negedge clk);
        #1;
        c++;
      end while (valid_out !== 1'b1 && c < 50);
      n_vec++;
      if (c >= 50) begin
        n_bad++;
        $display("FAIL reset_setup: valid_out=%b, required 1", valid_out);
      end
    end
    #1;
    rst_n = 1'b0;
    hq.delete(); pq.delete(); eq.delete();
    hdr_busy = 1'b0; pl_busy = 1'b0; stall_pend = 1'b0;
    #1;
    check_idle("reset_mid_packet");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check_idle("mid_reset_release");
    add_packet_model(32'hF1F2F3F4, 1, 2, 4);
    drain("post_reset", 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
